// File: rtl/shared_ram_arbiter.sv
// Two-requester round-robin arbiter for the shared 2 KiB byte RAM.
// It arbitrates between the M68K and the Z80, drives the registered RAM port,
// and returns per-side ack and read data, M68K DTACK and Z80 WAIT.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | pick an eligible requester; register the RAM address/data/we
// ACCESS  | RAM samples the address; write strobe is dropped
// CAPTURE | RAM data valid; latch into owner's dout and ack if still requested
module shared_ram_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              m68k_req,
  input  logic              m68k_we,
  input  logic [ADDR_W-1:0] m68k_addr,
  input  logic [DATA_W-1:0] m68k_din,
  output logic [DATA_W-1:0] m68k_dout,
  output logic              m68k_dtack_n,
  input  logic              z80_req,
  input  logic              z80_we,
  input  logic [ADDR_W-1:0] z80_addr,
  input  logic [DATA_W-1:0] z80_din,
  output logic [DATA_W-1:0] z80_dout,
  output logic              z80_wait_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE} state_t;

  localparam logic OWN_M68K = 1'b0;
  localparam logic OWN_Z80  = 1'b1;

  state_t             r_state;
  logic               r_owner;
  logic               r_last_grant;
  logic               r_acc_we;
  logic               r_m_ack;
  logic               r_z_ack;
  logic               r_m_served;
  logic               r_z_served;
  logic [DATA_W-1:0]  r_m_dout;
  logic [DATA_W-1:0]  r_z_dout;
  logic [ADDR_W-1:0]  r_ram_addr;
  logic               r_ram_we;
  logic [DATA_W-1:0]  r_ram_din;

  logic               w_m_elig;
  logic               w_z_elig;
  logic               w_grant_z80;
  logic               w_owner_req;
  logic [DATA_W-1:0]  w_cap_data;

  // A side may be granted only after its previous transfer was released.
  assign w_m_elig    = m68k_req & ~r_m_served;
  assign w_z_elig    = z80_req & ~r_z_served;
  // Z80 wins when alone, or on a tie when the M68K had the last grant.
  assign w_grant_z80 = w_z_elig & (~w_m_elig | (r_last_grant == OWN_M68K));
  assign w_owner_req = (r_owner == OWN_Z80) ? z80_req : m68k_req;
  // Writes echo the data that was written rather than the RAM's old contents.
  assign w_cap_data  = r_acc_we ? r_ram_din : ram_dout;

  // Arbitration FSM, RAM port registers and per-side handshake.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_M68K;
      r_last_grant <= OWN_Z80;
      r_acc_we     <= 1'b0;
      r_m_ack      <= 1'b0;
      r_z_ack      <= 1'b0;
      r_m_served   <= 1'b0;
      r_z_served   <= 1'b0;
      r_m_dout     <= '0;
      r_z_dout     <= '0;
      r_ram_addr   <= '0;
      r_ram_we     <= 1'b0;
      r_ram_din    <= '0;
    end else begin
      // A released request frees the side for its next transfer.
      if (!m68k_req) begin
        r_m_ack    <= 1'b0;
        r_m_served <= 1'b0;
      end
      if (!z80_req) begin
        r_z_ack    <= 1'b0;
        r_z_served <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_m_elig || w_z_elig) begin
            r_owner      <= w_grant_z80;
            r_last_grant <= w_grant_z80;
            r_acc_we     <= w_grant_z80 ? z80_we : m68k_we;
            r_ram_we     <= w_grant_z80 ? z80_we : m68k_we;
            r_ram_addr   <= w_grant_z80 ? z80_addr : m68k_addr;
            r_ram_din    <= w_grant_z80 ? z80_din : m68k_din;
            r_state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_ram_we <= 1'b0;
          r_state  <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // A request dropped here is abandoned; any write already landed.
          if (w_owner_req) begin
            if (r_owner == OWN_Z80) begin
              r_z_dout   <= w_cap_data;
              r_z_ack    <= 1'b1;
              r_z_served <= 1'b1;
            end else begin
              r_m_dout   <= w_cap_data;
              r_m_ack    <= 1'b1;
              r_m_served <= 1'b1;
            end
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m68k_dout    = r_m_dout;
  assign m68k_dtack_n = ~r_m_ack;
  assign z80_dout     = r_z_dout;
  assign z80_wait_n   = ~(z80_req & ~r_z_ack);
  assign ram_addr     = r_ram_addr;
  assign ram_we       = r_ram_we;
  assign ram_din      = r_ram_din;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Directed bench for shared_ram_arbiter with a synchronous byte RAM model.
module tb_shared_ram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        m68k_req, m68k_we, z80_req, z80_we;
  logic [10:0] m68k_addr, z80_addr;
  logic [7:0]  m68k_din, z80_din;
  logic [7:0]  m68k_dout, z80_dout;
  logic        m68k_dtack_n, z80_wait_n;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  logic [7:0]  mem [0:2047];
  logic        pre_en;
  logic [10:0] pre_addr;
  logic [7:0]  pre_data;

  int errors = 0;
  int checks = 0;

  always #5 clk_sys = ~clk_sys;

  shared_ram_arbiter #(.ADDR_W(11), .DATA_W(8)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .m68k_req(m68k_req), .m68k_we(m68k_we), .m68k_addr(m68k_addr),
    .m68k_din(m68k_din), .m68k_dout(m68k_dout), .m68k_dtack_n(m68k_dtack_n),
    .z80_req(z80_req), .z80_we(z80_we), .z80_addr(z80_addr),
    .z80_din(z80_din), .z80_dout(z80_dout), .z80_wait_n(z80_wait_n),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Read-first synchronous RAM with a bench-side preload port.
  always @(posedge clk_sys) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_sys);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [10:0] a, input logic [7:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    step(1);
    pre_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    m68k_req = 0; m68k_we = 0; m68k_addr = '0; m68k_din = '0;
    z80_req = 0; z80_we = 0; z80_addr = '0; z80_din = '0;
    step(2);
    preload(11'h7FF, 8'hC3); preload(11'h020, 8'h21); preload(11'h030, 8'h31);
    preload(11'h021, 8'h22); preload(11'h031, 8'h32); preload(11'h060, 8'h66);
    preload(11'h040, 8'hA0); preload(11'h041, 8'hA1); preload(11'h042, 8'hA2);
    preload(11'h055, 8'h77);

    // Reset state
    chk("rst_dtack_n", 32'(m68k_dtack_n), 32'd1);
    chk("rst_wait_n", 32'(z80_wait_n), 32'd1);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_din", 32'(ram_din), 32'h0);
    chk("rst_m_dout", 32'(m68k_dout), 32'h0);
    chk("rst_z_dout", 32'(z80_dout), 32'h0);
    reset = 1'b0;
    step(1);

    // M68K write 0x5A to 0x123
    m68k_req = 1; m68k_we = 1; m68k_addr = 11'h123; m68k_din = 8'h5A;
    step(1);
    chk("w_ram_we_hi", 32'(ram_we), 32'd1);
    chk("w_ram_addr", 32'(ram_addr), 32'h123);
    chk("w_ram_din", 32'(ram_din), 32'h5A);
    step(1);
    chk("w_ram_we_lo", 32'(ram_we), 32'd0);
    chk("w_dtack_early", 32'(m68k_dtack_n), 32'd1);
    step(1);
    chk("w_dtack", 32'(m68k_dtack_n), 32'd0);
    chk("w_mem", 32'(mem[11'h123]), 32'h5A);
    m68k_req = 0;
    step(1);
    chk("w_dtack_rel", 32'(m68k_dtack_n), 32'd1);

    // M68K read back 0x123
    m68k_req = 1; m68k_we = 0; m68k_din = 8'h00;
    step(2);
    chk("r_dtack_early", 32'(m68k_dtack_n), 32'd1);
    step(1);
    chk("r_dtack", 32'(m68k_dtack_n), 32'd0);
    chk("r_dout", 32'(m68k_dout), 32'h5A);
    m68k_req = 0;
    step(1);
    chk("r_dtack_rel", 32'(m68k_dtack_n), 32'd1);

    // Z80 read of 0x7FF
    z80_req = 1; z80_we = 0; z80_addr = 11'h7FF;
    #1;
    chk("z_wait_imm", 32'(z80_wait_n), 32'd0);
    step(2);
    chk("z_wait_hold", 32'(z80_wait_n), 32'd0);
    step(1);
    chk("z_wait_rel", 32'(z80_wait_n), 32'd1);
    chk("z_dout", 32'(z80_dout), 32'hC3);
    z80_req = 0;
    step(1);

    // Contention after reset: M68K wins the first tie
    reset = 1; step(1); reset = 0;
    m68k_req = 1; m68k_we = 0; m68k_addr = 11'h020;
    z80_req = 1; z80_we = 0; z80_addr = 11'h030;
    step(3);
    chk("c1_m_dtack", 32'(m68k_dtack_n), 32'd0);
    chk("c1_m_dout", 32'(m68k_dout), 32'h21);
    chk("c1_z_wait", 32'(z80_wait_n), 32'd0);
    step(1);
    chk("c1_z_addr", 32'(ram_addr), 32'h030);
    step(1);
    chk("c1_z_wait5", 32'(z80_wait_n), 32'd0);
    step(1);
    chk("c1_z_ack", 32'(z80_wait_n), 32'd1);
    chk("c1_z_dout", 32'(z80_dout), 32'h31);
    m68k_req = 0; z80_req = 0;
    step(1);

    // Lone M68K access, then a tie: Z80 wins
    m68k_req = 1; m68k_addr = 11'h020;
    step(3);
    m68k_req = 0;
    step(1);
    m68k_req = 1; m68k_addr = 11'h021;
    z80_req = 1; z80_addr = 11'h031;
    step(3);
    chk("c2_z_ack", 32'(z80_wait_n), 32'd1);
    chk("c2_z_dout", 32'(z80_dout), 32'h32);
    chk("c2_m_wait", 32'(m68k_dtack_n), 32'd1);
    step(3);
    chk("c2_m_dtack", 32'(m68k_dtack_n), 32'd0);
    chk("c2_m_dout", 32'(m68k_dout), 32'h22);
    m68k_req = 0; z80_req = 0;
    step(1);

    // M68K holds ack for 20 cycles while the Z80 does three reads
    m68k_req = 1; m68k_addr = 11'h060;
    step(3);
    chk("h_m_dtack", 32'(m68k_dtack_n), 32'd0);
    for (int k = 0; k < 3; k++) begin
      z80_req = 1; z80_addr = 11'h040 + 11'(k);
      step(3);
      chk("h_z_ack", 32'(z80_wait_n), 32'd1);
      chk("h_z_dout", 32'(z80_dout), 32'hA0 + 32'(k));
      z80_req = 0;
      step(1);
    end
    step(5);
    chk("h_m_dtack_end", 32'(m68k_dtack_n), 32'd0);
    chk("h_m_dout_end", 32'(m68k_dout), 32'h66);
    chk("h_no_regrant", 32'(ram_addr), 32'h042);
    m68k_req = 0;
    step(1);
    chk("h_m_rel", 32'(m68k_dtack_n), 32'd1);

    // M68K write with request dropped at CAPTURE
    m68k_req = 1; m68k_we = 1; m68k_addr = 11'h010; m68k_din = 8'hFF;
    step(2);
    m68k_req = 0; m68k_we = 0;
    step(1);
    chk("d_dtack", 32'(m68k_dtack_n), 32'd1);
    chk("d_mem", 32'(mem[11'h010]), 32'hFF);
    step(1);
    chk("d_dtack2", 32'(m68k_dtack_n), 32'd1);
    m68k_req = 1; m68k_din = 8'h00;
    step(3);
    chk("d_next_dtack", 32'(m68k_dtack_n), 32'd0);
    chk("d_next_dout", 32'(m68k_dout), 32'hFF);
    m68k_req = 0;
    step(1);

    // Reset during ACCESS of a Z80 read
    z80_req = 1; z80_addr = 11'h055;
    step(1);
    reset = 1;
    step(1);
    reset = 0;
    chk("x_z_dout", 32'(z80_dout), 32'h0);
    chk("x_m_dout", 32'(m68k_dout), 32'h0);
    chk("x_dtack", 32'(m68k_dtack_n), 32'd1);
    chk("x_wait", 32'(z80_wait_n), 32'd0);
    step(2);
    chk("x_wait2", 32'(z80_wait_n), 32'd0);
    step(1);
    chk("x_z_ack", 32'(z80_wait_n), 32'd1);
    chk("x_z_dout2", 32'(z80_dout), 32'h77);
    z80_req = 0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
